// File: rtl/microcode_sequencer.sv
// microcode_sequencer: walks one instruction's micro-op list, issuing a FETCH then a
// WRITE clock per micro-op, and pads the instruction out to a fixed clock budget.
module microcode_sequencer #(
    parameter int unsigned UC_ADDR_W    = 8,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned SHORT_CLOCKS = 5,
    parameter int unsigned LONG_CLOCKS  = 7,
    parameter int unsigned NOP_SEL      = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pause,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [UC_ADDR_W-1:0] instr_uc_addr,
    input  logic                 instr_long,
    output logic [UC_ADDR_W-1:0] uc_addr,
    input  logic [2*REG_W+2:0]   uc_data,
    output logic [1:0]           current_cycle,
    output logic [REG_W-1:0]     bus_input_selector,
    output logic [REG_W-1:0]     bus_output_selector,
    output logic [1:0]           increment_selector,
    output logic                 instr_done,
    output logic                 uc_error
);

    // Wide enough for count+1+2 at the long budget without overflow.
    localparam int unsigned CNT_W = $clog2(LONG_CLOCKS + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_PAD   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CYC_NONE      = 2'd0,
        CYC_REG_FETCH = 2'd1,
        CYC_REG_WRITE = 2'd2
    } cycle_e;

    state_e               state, state_nxt;
    cycle_e               cyc;
    logic [UC_ADDR_W-1:0] uc_pc, pc_nxt;
    logic [CNT_W-1:0]     count, count_nxt, cnt_inc;
    logic [CNT_W-1:0]     budget, budget_nxt;
    logic                 err_set;
    logic                 ready_en;

    // Micro-op word fields
    logic [REG_W-1:0] f_in, f_out;
    logic [1:0]       f_inc;
    logic             f_last;

    assign f_in   = uc_data[REG_W-1:0];
    assign f_out  = uc_data[2*REG_W-1:REG_W];
    assign f_inc  = uc_data[2*REG_W+1:2*REG_W];
    assign f_last = uc_data[2*REG_W+2];

    assign cnt_inc       = count + CNT_W'(1);
    assign uc_addr       = uc_pc;
    assign current_cycle = cyc;

    // Holds instr_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // State, program counter, clock counter, budget and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            uc_pc    <= '0;
            count    <= '0;
            budget   <= CNT_W'(SHORT_CLOCKS);
            uc_error <= 1'b0;
        end else begin
            state  <= state_nxt;
            uc_pc  <= pc_nxt;
            count  <= count_nxt;
            budget <= budget_nxt;
            if (err_set) uc_error <= 1'b1;
        end
    end

    // Next-state and register-stage outputs; pause holds everything and idles outputs.
    always_comb begin
        state_nxt           = state;
        pc_nxt              = uc_pc;
        count_nxt           = count;
        budget_nxt          = budget;
        err_set             = 1'b0;
        instr_ready         = 1'b0;
        instr_done          = 1'b0;
        cyc                 = CYC_NONE;
        bus_input_selector  = '0;
        bus_output_selector = REG_W'(NOP_SEL);
        increment_selector  = 2'd0;

        if (!pause) begin
            case (state)
                S_IDLE: begin
                    instr_ready = ready_en;
                    if (instr_valid && ready_en) begin
                        pc_nxt     = instr_uc_addr;
                        count_nxt  = CNT_W'(1);
                        budget_nxt = instr_long ? CNT_W'(LONG_CLOCKS) : CNT_W'(SHORT_CLOCKS);
                        state_nxt  = S_FETCH;
                    end
                end
                S_FETCH: begin
                    cyc                 = CYC_REG_FETCH;
                    bus_input_selector  = f_in;
                    bus_output_selector = f_out;
                    count_nxt           = cnt_inc;
                    state_nxt           = S_WRITE;
                end
                S_WRITE: begin
                    cyc                 = CYC_REG_WRITE;
                    bus_input_selector  = f_in;
                    bus_output_selector = f_out;
                    increment_selector  = f_inc;
                    count_nxt           = cnt_inc;
                    if (f_last) begin
                        if (cnt_inc >= budget) begin
                            instr_done = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            state_nxt  = S_PAD;
                        end
                    end else if (cnt_inc + CNT_W'(2) <= budget) begin
                        pc_nxt    = uc_pc + 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        err_set    = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
                S_PAD: begin
                    count_nxt = cnt_inc;
                    if (cnt_inc >= budget) begin
                        instr_done = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a ROM model drives uc_data, each accepted
// instruction pushes its expected per-clock output sequence, the monitor pops and compares.
module tb_microcode_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned RW  = 5;
    localparam logic [RW-1:0] NOP = 5'd0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pause;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] instr_uc_addr;
    logic          instr_long;
    logic [AW-1:0] uc_addr;
    logic [2*RW+2:0] uc_data;
    logic [1:0]    current_cycle;
    logic [RW-1:0] bus_input_selector;
    logic [RW-1:0] bus_output_selector;
    logic [1:0]    increment_selector;
    logic          instr_done;
    logic          uc_error;

    logic [2*RW+2:0] rom [256];

    typedef struct {
        logic [1:0]    cyc;
        logic [RW-1:0] in_sel;
        logic [RW-1:0] out_sel;
        logic [1:0]    inc;
        logic          done;
        logic [AW-1:0] addr;
        logic          chk_addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_err  = 1'b0;

    microcode_sequencer #(
        .UC_ADDR_W(AW), .REG_W(RW), .SHORT_CLOCKS(5), .LONG_CLOCKS(7), .NOP_SEL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pause(pause),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_uc_addr(instr_uc_addr), .instr_long(instr_long),
        .uc_addr(uc_addr), .uc_data(uc_data),
        .current_cycle(current_cycle),
        .bus_input_selector(bus_input_selector),
        .bus_output_selector(bus_output_selector),
        .increment_selector(increment_selector),
        .instr_done(instr_done), .uc_error(uc_error)
    );

    always #5 clk = ~clk;

    assign uc_data = rom[uc_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic logic [2*RW+2:0] mk(input logic last, input logic [1:0] inc,
                                            input logic [RW-1:0] out_s, input logic [RW-1:0] in_s);
        return {last, inc, out_s, in_s};
    endfunction

    task automatic push_exp(input logic [1:0] cyc, input logic [2*RW+2:0] w,
                            input logic done, input logic [AW-1:0] a);
        exp_t e;
        e.cyc      = cyc;
        e.in_sel   = (cyc == 2'd0) ? '0 : w[RW-1:0];
        e.out_sel  = (cyc == 2'd0) ? NOP : w[2*RW-1:RW];
        e.inc      = (cyc == 2'd2) ? w[2*RW+1:2*RW] : 2'd0;
        e.done     = done;
        e.addr     = a;
        e.chk_addr = (cyc != 2'd0);
        sb.push_back(e);
    endtask

    // Expected clock-by-clock behaviour from the accept clock (count 1) onward.
    task automatic build_expected(input logic [AW-1:0] addr, input logic lng);
        int budget = lng ? 7 : 5;
        int c = 1;
        logic [AW-1:0] pc = addr;
        logic [2*RW+2:0] w;
        bit fin = 0;
        while (!fin) begin
            w = rom[pc];
            push_exp(2'd1, w, 1'b0, pc);
            c++;                                  // count seen during WRITE
            if (w[2*RW+2]) begin
                if (c + 1 == budget) begin
                    push_exp(2'd2, w, 1'b1, pc);
                end else begin
                    push_exp(2'd2, w, 1'b0, pc);
                    c++;                          // count seen in first PAD
                    while (c + 1 != budget) begin
                        push_exp(2'd0, '0, 1'b0, pc);
                        c++;
                    end
                    push_exp(2'd0, '0, 1'b1, pc);
                end
                fin = 1;
            end else if (c + 3 <= budget) begin
                push_exp(2'd2, w, 1'b0, pc);
                pc = pc + 8'd1;
                c++;
            end else begin
                push_exp(2'd2, w, 1'b1, pc);
                exp_err = 1'b1;
                fin = 1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cyc"},  32'(current_cycle), 32'd0);
        check_eq({tag, "_out"},  32'(bus_output_selector), 32'(NOP));
        check_eq({tag, "_in"},   32'(bus_input_selector), 32'd0);
        check_eq({tag, "_inc"},  32'(increment_selector), 32'd0);
        check_eq({tag, "_done"}, 32'(instr_done), 32'd0);
        check_eq({tag, "_rdy"},  32'(instr_ready), 32'd0);
    endtask

    // Offers one instruction, then compares every following clock against the scoreboard.
    // pause_at: index of the scoreboard entry before which pause is held for pause_len clocks.
    task automatic run_instr(input string tag, input logic [AW-1:0] addr, input logic lng,
                             input int pause_at, input int pause_len);
        exp_t e;
        int idx = 0;
        build_expected(addr, lng);
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_uc_addr = addr;
        instr_long    = lng;
        #1 check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        while (sb.size() > 0) begin
            @(negedge clk);
            if (idx == pause_at && pause_len > 0) begin
                pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    #1 check_idle_outputs({tag, "_pause"});
                    @(negedge clk);
                end
                pause = 1'b0;
            end
            #1;
            e = sb.pop_front();
            check_eq($sformatf("%s_cyc%0d", tag, idx),  32'(current_cycle), 32'(e.cyc));
            check_eq($sformatf("%s_in%0d", tag, idx),   32'(bus_input_selector), 32'(e.in_sel));
            check_eq($sformatf("%s_out%0d", tag, idx),  32'(bus_output_selector), 32'(e.out_sel));
            check_eq($sformatf("%s_inc%0d", tag, idx),  32'(increment_selector), 32'(e.inc));
            check_eq($sformatf("%s_done%0d", tag, idx), 32'(instr_done), 32'(e.done));
            if (e.chk_addr)
                check_eq($sformatf("%s_addr%0d", tag, idx), 32'(uc_addr), 32'(e.addr));
            check_eq($sformatf("%s_nordy%0d", tag, idx), 32'(instr_ready), 32'd0);
            idx++;
        end
        @(negedge clk);
        #1 check_eq({tag, "_ready_after"}, 32'(instr_ready), 32'd1);
        check_eq({tag, "_err"}, 32'(uc_error), 32'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[8'h10] = mk(1'b1, 2'd0, 5'd4, 5'd3);
        rom[8'h20] = mk(1'b0, 2'd0, 5'd2, 5'd1);
        rom[8'h21] = mk(1'b1, 2'd1, 5'd6, 5'd5);
        rom[8'h30] = mk(1'b0, 2'd2, 5'd7, 5'd8);
        rom[8'h31] = mk(1'b0, 2'd3, 5'd9, 5'd10);
        rom[8'h32] = mk(1'b1, 2'd0, 5'd11, 5'd12);
        rom[8'h40] = mk(1'b1, 2'd3, 5'd13, 5'd14);
        rom[8'h50] = mk(1'b0, 2'd0, 5'd15, 5'd16);
        rom[8'h51] = mk(1'b0, 2'd1, 5'd17, 5'd18);
        rom[8'h52] = mk(1'b1, 2'd2, 5'd19, 5'd20);
        rom[8'h60] = mk(1'b1, 2'd2, 5'd21, 5'd22);
        rom[8'hFF] = mk(1'b0, 2'd0, 5'd23, 5'd24);
        rom[8'h00] = mk(1'b1, 2'd3, 5'd25, 5'd26);

        reset_n       = 1'b0;
        pause         = 1'b0;
        instr_valid   = 1'b0;
        instr_uc_addr = '0;
        instr_long    = 1'b0;

        #1 check_idle_outputs("rst");
        check_eq("rst_err", 32'(uc_error), 32'd0);
        check_eq("rst_addr", 32'(uc_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_instr("t1_short1op", 8'h10, 1'b0, -1, 0);
        run_instr("t2_short2op", 8'h20, 1'b0, -1, 0);
        run_instr("t3_long3op",  8'h30, 1'b1, -1, 0);
        run_instr("t3_long1op",  8'h40, 1'b1, -1, 0);
        run_instr("wrap",        8'hFF, 1'b0, -1, 0);
        run_instr("t4_overrun",  8'h50, 1'b0, -1, 0);
        run_instr("t5_pause",    8'h60, 1'b0, 1, 4);
        run_instr("after_err",   8'h20, 1'b0, -1, 0);

        // Asynchronous reset in the middle of a FETCH clock
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_uc_addr = 8'h10;
        instr_long    = 1'b0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        #1 check_eq("t6_fetch_cyc", 32'(current_cycle), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("t6_rst");
        check_eq("t6_err", 32'(uc_error), 32'd0);
        check_eq("t6_addr", 32'(uc_addr), 32'd0);
        exp_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_eq("t6_rdy_low", 32'(instr_ready), 32'd0);
        run_instr("t6_fresh", 8'h10, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
